// File: rtl/ram_param_clr.sv
// ---------------------------------------------------------------------------
// ram_param_clr
//   Parametrised single-port synchronous RAM with a registered read port, a
//   selectable read-during-write mode and a hardware clear sequencer. After
//   reset the sequencer writes zero to every word, one word per clock edge.
//   Host accesses are accepted only while `ready` is high.
//
// Parameters
//   WIDTH     data word width in bits
//   ADDR_W    address width; DEPTH = 2**ADDR_W words
//   WR_FIRST  0: a write cycle returns the old word; 1: it returns `val`
//   CLR_EN    1: zero-fill all words after reset; 0: start idle immediately
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous reset, active low
//   val      write data
//   load     write enable, sampled on the rising edge
//   address  word address shared by the read and the write
//   out      registered read data (1-cycle latency)
//   ready    1 = host accesses accepted; 0 = clear in progress or in reset
// ---------------------------------------------------------------------------
module ram_param_clr #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned WR_FIRST = 0,
    parameter int unsigned CLR_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  val,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out,
    output logic              ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    // Reset state depends on whether the clear sweep is enabled.
    localparam state_t RST_STATE = (CLR_EN != 0) ? S_CLEAR : S_IDLE;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  clr_addr;
    logic [CNT_W-1:0]  clr_addr_nxt;
    logic [WIDTH-1:0]  out_nxt;
    logic              ready_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    // Storage array; deliberately not reset, contents come from the sweep.
    logic [WIDTH-1:0]  mem [DEPTH];

    // State register, sweep counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            clr_addr <= '0;
            out      <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
            out      <= out_nxt;
            ready    <= ready_nxt;
        end
    end

    // Next-state: the edge that clears the last word ends the sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = S_IDLE;
            S_IDLE:  state_nxt = S_IDLE;
            default: state_nxt = RST_STATE;
        endcase
    end

    // Output / datapath decode: memory write port and next register values.
    always_comb begin
        mem_we       = 1'b0;
        mem_waddr    = address;
        mem_wdata    = val;
        clr_addr_nxt = clr_addr;
        out_nxt      = out;
        ready_nxt    = ready;
        case (state)
            S_CLEAR: begin
                // Host inputs are ignored; zero one word per edge.
                mem_we       = 1'b1;
                mem_waddr    = clr_addr[ADDR_W-1:0];
                mem_wdata    = '0;
                clr_addr_nxt = clr_addr + CNT_W'(1);
                out_nxt      = '0;
                ready_nxt    = (clr_addr == LAST_ADDR);
            end
            S_IDLE: begin
                ready_nxt = 1'b1;
                // First idle edge with CLR_EN=0 has ready low: drop the access.
                if (ready) begin
                    mem_we = load;
                    if (load && (WR_FIRST != 0)) begin
                        out_nxt = val;
                    end else begin
                        out_nxt = mem[address];
                    end
                end else begin
                    out_nxt = '0;
                end
            end
            default: begin
                out_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Single write port shared by the sweep and the host.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
